// File: rtl/aes_iter_ctrl_if.sv
// Job/result handshake bundle for the iterative AES controller.
// master = job source / result sink, slave = the controller.
interface aes_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_mode;

  modport master (
    output in_valid, in_mode, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_mode, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encrypt/decrypt controller: one job at a time, one round
// per clock through shared round logic, key schedule expanded at accept.
module aes_iter_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_iter_ctrl_if.slave   bus,
  input  logic             abort,
  output logic             busy,
  output logic [3:0]       round_idx,
  output logic [CNT_W-1:0] jobs_done,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [1407:0]     key_sched_q, key_sched_d;
  logic [127:0]      blk_q, blk_d;
  logic              mode_q, mode_d;
  logic [3:0]        round_q, round_d;
  logic [127:0]      out_data_q, out_data_d;
  logic              out_mode_q, out_mode_d;
  logic [CNT_W-1:0]  jobs_q, jobs_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  // GF(2^8) arithmetic and the S-box built from inversion + affine map.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^-1 for a != 0, and 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = ginv(x);
    return v ^ rol(v, 1) ^ rol(v, 2) ^ rol(v, 3) ^ rol(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rol(x, 1) ^ rol(x, 3) ^ rol(x, 6) ^ 8'h05);
  endfunction

  // Byte i of a block sits at [127-8i -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  // Circulant matrix: coefficient of a_j in b_r is m[(j-r) mod 4]
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    o = '0;
    m[0] = inv ? 8'h0e : 8'h02;
    m[1] = inv ? 8'h0b : 8'h03;
    m[2] = inv ? 8'h0d : 8'h01;
    m[3] = inv ? 8'h09 : 8'h01;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], m[(j - r + 4) % 4]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  // Round key r occupies [1407-128r -: 128]
  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    o = '0;
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  logic accept, out_valid, out_hs;

  assign out_valid    = (fsm_q == DONE);
  assign bus.in_ready = ((fsm_q == IDLE) || (fsm_q == DONE && bus.out_ready)) && !abort;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = out_valid && bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_mode  = out_mode_q;
  assign busy          = (fsm_q != IDLE);
  assign round_idx     = round_q;
  assign jobs_done     = jobs_q;
  assign stall_cycles  = stall_q;

  // Next-state, round datapath and status counter updates
  always_comb begin
    logic [1407:0] ks;
    logic [127:0]  rk, rnd;
    logic          fin;
    int            rk_idx;
    fsm_d       = fsm_q;
    key_sched_d = key_sched_q;
    blk_d       = blk_q;
    mode_d      = mode_q;
    round_d     = round_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    jobs_d      = jobs_q;
    stall_d     = stall_q;
    ks          = '0;
    rk          = '0;
    rnd         = '0;
    fin         = (round_q == 4'd10);
    rk_idx      = 0;

    if (out_valid && !bus.out_ready && stall_q != '1) stall_d = stall_q + 1'b1;
    // an aborted result is dropped, so it does not count as delivered
    if (out_hs && !abort && jobs_q != '1) jobs_d = jobs_q + 1'b1;

    if (abort) begin
      fsm_d   = IDLE;
      round_d = 4'd0;
    end else if (accept) begin
      ks          = key_expand(bus.in_key);
      key_sched_d = ks;
      mode_d      = bus.in_mode;
      blk_d       = bus.in_data ^ (bus.in_mode ? ks[127:0] : ks[1407:1280]);
      round_d     = 4'd1;
      fsm_d       = RUN;
    end else begin
      case (fsm_q)
        RUN: begin
          rk_idx = mode_q ? 10 - int'(round_q) : int'(round_q);
          rk     = key_sched_q[1407-128*rk_idx -: 128];
          if (!mode_q) begin
            rnd = shift_rows(sub_bytes(blk_q, 1'b0), 1'b0);
            if (!fin) rnd = mix_columns(rnd, 1'b0);
            rnd = rnd ^ rk;
          end else begin
            rnd = sub_bytes(shift_rows(blk_q, 1'b1), 1'b1) ^ rk;
            if (!fin) rnd = mix_columns(rnd, 1'b1);
          end
          blk_d = rnd;
          if (fin) begin
            out_data_d = rnd;
            out_mode_d = mode_q;
            round_d    = 4'd0;
            fsm_d      = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
        DONE: if (bus.out_ready) fsm_d = IDLE;
        default: ;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      key_sched_q <= '0;
      blk_q       <= '0;
      mode_q      <= 1'b0;
      round_q     <= 4'd0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      jobs_q      <= '0;
      stall_q     <= '0;
    end else begin
      fsm_q       <= fsm_d;
      key_sched_q <= key_sched_d;
      blk_q       <= blk_d;
      mode_q      <= mode_d;
      round_q     <= round_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      jobs_q      <= jobs_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed bench for aes_iter_ctrl using FIPS-197 vectors.
module tb_aes_iter_ctrl;
  localparam int CNT_W = 16;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             abort;
  logic             busy;
  logic [3:0]       round_idx;
  logic [CNT_W-1:0] jobs_done;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  aes_iter_ctrl_if bus ();

  aes_iter_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .abort        (abort),
    .busy         (busy),
    .round_idx    (round_idx),
    .jobs_done    (jobs_done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic mode, input logic [127:0] key, input logic [127:0] data);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_key   = key;
    bus.in_data  = data;
    #1;
    chk("in_ready_at_offer", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_mode  = ~mode;
    bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    chk("round_idx_after_accept", round_idx, 1);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic run_rounds(input logic [127:0] exp_data, input logic exp_mode);
    for (int k = 1; k <= 10; k++) begin
      chk("round_idx_step", round_idx, k);
      chk("out_valid_low_in_run", bus.out_valid, 0);
      tick();
    end
    chk("out_valid_at_10", bus.out_valid, 1);
    chk("out_data", bus.out_data, exp_data);
    chk("out_mode", bus.out_mode, exp_mode);
    chk("round_idx_done", round_idx, 0);
    chk("busy_done", busy, 1);
  endtask

  task automatic consume(input int exp_jobs);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_after_hs", bus.out_valid, 0);
    chk("jobs_done", jobs_done, exp_jobs);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    bit seen_valid;
    rst_n         = 1'b0;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_key    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_rst", bus.in_ready, 1);

    // C.1 encrypt, then decrypt back
    start_job(1'b0, K1, P1);
    run_rounds(C1, 1'b0);
    consume(1);
    chk("stall_none", stall_cycles, 0);
    start_job(1'b1, K1, C1);
    run_rounds(P1, 1'b1);
    consume(2);

    // backpressure, with the next job held waiting
    start_job(1'b0, K2, P2);
    run_rounds(C2, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_mode  = 1'b0;
    bus.in_key   = K1;
    bus.in_data  = P1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready_low", bus.in_ready, 0);
      tick();
      chk("bp_out_data_held", bus.out_data, C2);
      chk("bp_out_valid_held", bus.out_valid, 1);
      chk("bp_round_idx", round_idx, 0);
    end
    chk("stall_cycles_5", stall_cycles, 5);
    chk("jobs_before_release", jobs_done, 2);

    // release output and accept the next job at the same edge
    bus.out_ready = 1'b1;
    start_job(1'b0, K1, P1);
    bus.out_ready = 1'b0;
    chk("b2b_jobs_done", jobs_done, 3);
    chk("b2b_out_valid", bus.out_valid, 0);
    run_rounds(C1, 1'b0);
    consume(4);
    chk("stall_unchanged", stall_cycles, 5);

    // abort at round 4
    start_job(1'b0, K1, P1);
    repeat (3) tick();
    chk("abort_round_4", round_idx, 4);
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    chk("abort_in_ready", bus.in_ready, 0);
    tick();
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_round_idx", round_idx, 0);
    chk("abort_jobs", jobs_done, 4);
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) seen_valid = 1'b1;
      tick();
    end
    chk("abort_no_valid", seen_valid, 0);
    start_job(1'b0, K1, P1);
    run_rounds(C1, 1'b0);
    consume(5);

    // async reset at round 7
    start_job(1'b0, K2, P2);
    repeat (6) tick();
    chk("reset_round_7", round_idx, 7);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_out_mode", bus.out_mode, 0);
    chk("arst_busy", busy, 0);
    chk("arst_round_idx", round_idx, 0);
    chk("arst_jobs", jobs_done, 0);
    chk("arst_stall", stall_cycles, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_busy_after", busy, 0);
    start_job(1'b1, K1, C1);
    run_rounds(P1, 1'b1);
    consume(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_iter_ctrl.md
Name: aes_iter_ctrl

Overview:
Iterative AES-128 engine controller. It accepts one encrypt or decrypt job at a time over a valid/ready handshake and latches the expanded key schedule. It then sequences one round per clock through shared round logic: aes_round for encrypt; aes_inv_round plus inv_shiftrows/inv_subbytes/addroundkey for decrypt. This replaces the fully unrolled aes_encrypt/aes_decrypt when area matters, and sits between the host bus adapter and the result FIFO.

Parameters:
CNT_W, 16, width of the jobs_done and stall_cycles status counters (both saturate).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  job request
in_ready  out  1  controller can accept a job this cycle
in_mode  in  1  0 = encrypt, 1 = decrypt
in_key  in  128  cipher key, byte 0 at [127:120]
in_data  in  128  plaintext (enc) or ciphertext (dec), byte 0 at [127:120]
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  128  result block
out_mode  out  1  mode of the job that produced out_data
abort  in  1  synchronous job cancel
busy  out  1  high in RUN and DONE
round_idx  out  4  current round, 0..10
jobs_done  out  CNT_W  count of completed output handshakes, saturating
stall_cycles  out  CNT_W  count of cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FSM=IDLE; out_valid, out_data, out_mode, busy, round_idx, jobs_done and stall_cycles all 0; the key schedule register and the state register are 0. in_ready is 1 from the first cycle after release.
- FSM states: IDLE, RUN, DONE.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready), gated by !abort.
- Accept (in_valid & in_ready at an edge):
  - Latch the aes_key_expansion output of in_key (1408 bits) and in_mode.
  - state <= in_data ^ rk[0] for encrypt, in_data ^ rk[10] for decrypt.
  - round_idx <= 1; FSM -> RUN.
- RUN, one round per edge:
  - Encrypt: round r (1..9) is aes_round with rk[r], is_final=0. r=10 is aes_round with rk[10], is_final=1.
  - Decrypt: round r (1..9) is aes_inv_round with rk[10-r]. r=10 is inv_shiftrows, then inv_subbytes, then XOR rk[0].
  - round_idx increments after each round.
  - On the r=10 edge: out_data <= result, out_mode <= job mode, out_valid <= 1, FSM -> DONE, round_idx <= 0.
- Latency: out_valid rises exactly 10 clocks after the accept edge. Throughput is 1 block per 11 cycles with zero backpressure, because the DONE-cycle handoff overlaps acceptance of the next job.
- DONE:
  - out_data and out_mode are held stable while out_valid=1 and out_ready=0; stall_cycles increments each such cycle.
  - On out_valid & out_ready: jobs_done increments and out_valid drops at that edge. If a new job is accepted at the same edge, go to RUN; otherwise go to IDLE.
- Simultaneous output handshake and input accept in DONE: both take effect at the same edge. The new job's key and data are used; the old result is already consumed.
- abort (any state): at the next edge FSM -> IDLE, out_valid <= 0, round_idx <= 0, busy <= 0.
  - The current job is dropped and is not counted.
  - in_ready is 0 during the abort cycle, so abort has priority over accept.
  - Counters are not cleared.
- in_key, in_data and in_mode are don't-care except at the accept edge; the controller never samples them during RUN.
- Counters stay at all-ones once reached (no wrap).
- rst_n low mid-RUN or mid-DONE: all registers clear immediately (asynchronously), the in-flight job is lost, and the controller is in IDLE on release.
- in_valid with in_ready=0: no state change; the requester must hold the request.

Test Plan:
- FIPS-197 C.1 encrypt: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 clocks after accept, round_idx steps 1..10, out_mode=0.
- Same key, decrypt 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_mode=1.
- Backpressure: encrypt key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734, out_ready held low 5 cycles -> out_data stays 3925841d02dc09fbdc118597196a0b32, in_ready=0 throughout, stall_cycles=5, then jobs_done=1 on release.
- Back-to-back: the C.1 encrypt job offered in the DONE cycle of the B encrypt job with out_ready=1 -> new job accepted at the same edge, second result 10 clocks later, jobs_done=2, no idle cycle.
- Abort at round_idx=4 -> next cycle FSM IDLE, out_valid never rises, jobs_done unchanged, a following C.1 job yields the correct ciphertext.
- rst_n pulsed low at round_idx=7 -> all outputs 0 immediately; after release in_ready=1, counters 0, and a following C.1 decrypt is correct.
